// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op codes,
// FSM states, default latencies and the signed 32-bit divide helper.
package ex_muldiv_unit_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    // Returns {remainder, quotient}. Works on magnitudes so 0x80000000 / -1
    // wraps to quotient 0x80000000, remainder 0. Caller excludes b == 0.
    function automatic logic [63:0] sdiv32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the ID/EX stage and the multiply/divide unit.
// start is a one-cycle strobe qualifying op/rs_val/rt_val; there is no ready:
// the decode stall controller must not raise start while busy is high.
interface ex_muldiv_unit_if;
    logic                        start;
    ex_muldiv_unit_pkg::md_op_e  op;
    logic [31:0]                 rs_val;
    logic [31:0]                 rt_val;
    logic                        busy;
    logic [31:0]                 hi;
    logic [31:0]                 lo;

    modport master (output start, op, rs_val, rt_val, input busy, hi, lo);
    modport slave  (input start, op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at
// start, held pending, and committed on the last busy cycle's closing edge.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   md,
    output md_state_e         dbg_state_o
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_ok_q, pend_ok_d;

    logic [63:0]        prod;
    logic [63:0]        sdiv_res;
    logic [31:0]        divisor;
    logic               div_zero;

    // Divisor is forced non-zero so the dividers never see zero; the result
    // is discarded through pend_ok instead.
    assign div_zero = (md.rt_val == 32'd0);
    assign divisor  = div_zero ? 32'd1 : md.rt_val;
    assign sdiv_res = sdiv32(md.rs_val, divisor);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        prod      = 64'd0;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    case (md.op)
                        MD_MULT: begin
                            prod      = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
                            pend_hi_d = prod[63:32];
                            pend_lo_d = prod[31:0];
                            pend_ok_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_MUL_RUN;
                        end
                        MD_MULTU: begin
                            prod      = {32'd0, md.rs_val} * {32'd0, md.rt_val};
                            pend_hi_d = prod[63:32];
                            pend_lo_d = prod[31:0];
                            pend_ok_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_MUL_RUN;
                        end
                        MD_DIV: begin
                            pend_hi_d = sdiv_res[63:32];
                            pend_lo_d = sdiv_res[31:0];
                            pend_ok_d = !div_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_DIV_RUN;
                        end
                        MD_DIVU: begin
                            pend_hi_d = md.rs_val % divisor;
                            pend_lo_d = md.rs_val / divisor;
                            pend_ok_d = !div_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_DIV_RUN;
                        end
                        MD_MTHI: hi_d = md.rs_val;
                        MD_MTLO: lo_d = md.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_ok_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign md.busy     = (state_q != ST_IDLE);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign dbg_state_o = state_q;

endmodule
